// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator offload requester.
// Optional build macro ACC_OFFLOAD_SPILL_EN is consumed by acc_offload_requester.
package acc_pkg;

    localparam int unsigned AccNumRs     = 3;
    localparam int unsigned AccDataWidth = 32;
    localparam int unsigned RegAddrW     = 5;

    // Instruction field positions (LSB of each 5-bit register address)
    localparam int unsigned Rs1Lsb = 15;
    localparam int unsigned Rs2Lsb = 20;
    localparam int unsigned Rs3Lsb = 27;
    localparam int unsigned RdLsb  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREDECODE,
        ST_WAIT_OPS,
        ST_ISSUE
    } acc_offl_state_e;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic                p_accept;
        logic                p_writeback;
        logic [AccNumRs-1:0] p_use_rs;
    } acc_prd_rsp_t;

    typedef struct packed {
        logic [31:0]                         instr;
        logic [AccNumRs-1:0][AccDataWidth-1:0] rs;
        logic [RegAddrW-1:0]                 rd;
    } acc_offl_req_t;

    // Source register address of operand idx
    function automatic logic [RegAddrW-1:0] acc_rs_addr(input logic [31:0] instr,
                                                        input int unsigned idx);
        case (idx)
            0:       return instr[Rs1Lsb +: RegAddrW];
            1:       return instr[Rs2Lsb +: RegAddrW];
            default: return instr[Rs3Lsb +: RegAddrW];
        endcase
    endfunction

endpackage

// File: rtl/acc_wb_scoreboard.sv
// Writeback scoreboard: per-register pending mask plus outstanding counter.
module acc_wb_scoreboard #(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_rd_i,
    output logic [31:0] mask_o,
    output logic        full_o,
    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]     r_mask;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     w_mask_next;
    logic            w_clr;

    // Responses with nothing outstanding are dropped entirely
    assign w_clr = clr_i && (r_cnt != '0);

    // Next mask: clear first so a same-rd set in the same cycle wins
    always_comb begin
        w_mask_next = r_mask;
        if (w_clr) w_mask_next[clr_rd_i] = 1'b0;
        if (set_i) w_mask_next[set_rd_i] = 1'b1;
        w_mask_next[0] = 1'b0;
    end

    // Mask and outstanding counter state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask <= '0;
            r_cnt  <= '0;
        end else begin
            r_mask <= w_mask_next;
            if (set_i && !w_clr)
                r_cnt <= r_cnt + 1'b1;
            else if (!set_i && w_clr)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign mask_o = r_mask;
    assign full_o = (r_cnt == CntW'(MaxOutstanding));
    assign busy_o = (r_cnt != '0);

endmodule

// File: rtl/acc_offload_requester.sv
// Core-side initiator of the accelerator predecode/offload protocol.
// Build macro ACC_OFFLOAD_SPILL_EN: replaces ISSUE with a one-entry output buffer.
module acc_offload_requester
    import acc_pkg::*;
#(
    parameter int unsigned NumRs          = AccNumRs,
    parameter int unsigned DataWidth      = AccDataWidth,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            instr_valid_i,
    output logic                            instr_ready_o,
    input  logic [31:0]                     instr_data_i,
    input  logic [NumRs-1:0][DataWidth-1:0] rs_i,
    input  logic [NumRs-1:0]                rs_valid_i,
    output acc_prd_req_t                    prd_req_o,
    input  acc_prd_rsp_t                    prd_rsp_i,
    output logic                            acc_req_valid_o,
    input  logic                            acc_req_ready_i,
    output logic [31:0]                     acc_req_instr_o,
    output logic [NumRs-1:0][DataWidth-1:0] acc_req_rs_o,
    output logic [4:0]                      acc_req_rd_o,
    input  logic                            acc_rsp_valid_i,
    input  logic [4:0]                      acc_rsp_rd_i,
    output logic                            acc_rsp_ready_o,
    output logic                            illegal_o,
    output logic [31:0]                     wb_pending_o,
    output logic                            busy_o
);

    acc_offl_state_e r_state;
    logic [31:0]     r_instr;
    acc_prd_rsp_t    r_rsp;
    acc_offl_req_t   r_req;
    logic            r_instr_ready;
    logic            r_acc_valid;
    logic            r_illegal;

    logic [NumRs-1:0][DataWidth-1:0] w_rs;
    logic [4:0]  w_rd;
    logic        w_ops_ready;
    logic        w_wb_clear;
    logic        w_go;
    logic        w_set;
    logic [31:0] w_mask;
    logic        w_sb_full;
    logic        w_sb_busy;

    assign w_rd = r_instr[RdLsb +: RegAddrW];

    // Operand readiness and masked operand capture values
    always_comb begin
        w_ops_ready = 1'b1;
        w_rs        = '0;
        for (int unsigned k = 0; k < NumRs; k++) begin
            if (r_rsp.p_use_rs[k]) begin
                w_rs[k] = rs_i[k];
                if (!rs_valid_i[k] || w_mask[acc_rs_addr(r_instr, k)])
                    w_ops_ready = 1'b0;
            end
        end
    end

    assign w_wb_clear = !r_rsp.p_writeback || (w_rd == '0) ||
                        (!w_mask[w_rd] && !w_sb_full);

`ifdef ACC_OFFLOAD_SPILL_EN
    // The buffer can take a new request when empty or draining this cycle
    assign w_go  = (r_state == ST_WAIT_OPS) && w_ops_ready && w_wb_clear &&
                   (!r_acc_valid || acc_req_ready_i);
    assign w_set = w_go && r_rsp.p_writeback && (w_rd != '0);
`else
    assign w_go  = (r_state == ST_WAIT_OPS) && w_ops_ready && w_wb_clear;
    assign w_set = (r_state == ST_ISSUE) && acc_req_ready_i &&
                   r_rsp.p_writeback && (w_rd != '0);
`endif

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_rsp         <= '0;
            r_req         <= '0;
            r_instr_ready <= 1'b1;
            r_acc_valid   <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        r_instr       <= instr_data_i;
                        r_instr_ready <= 1'b0;
                        r_state       <= ST_PREDECODE;
                    end
                end
                ST_PREDECODE: begin
                    r_rsp <= prd_rsp_i;
                    if (!prd_rsp_i.p_accept) begin
                        r_illegal     <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_OPS;
                    end
                end
                ST_WAIT_OPS: begin
                    if (w_go) begin
                        r_req.instr <= r_instr;
                        r_req.rs    <= w_rs;
                        r_req.rd    <= w_rd;
`ifdef ACC_OFFLOAD_SPILL_EN
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
`else
                        r_acc_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
`endif
                    end
                end
`ifndef ACC_OFFLOAD_SPILL_EN
                ST_ISSUE: begin
                    if (acc_req_ready_i) begin
                        r_acc_valid   <= 1'b0;
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
`ifdef ACC_OFFLOAD_SPILL_EN
            // Buffer occupancy: a load overrides a same-cycle drain
            if (w_go)
                r_acc_valid <= 1'b1;
            else if (acc_req_ready_i)
                r_acc_valid <= 1'b0;
`endif
        end
    end

    acc_wb_scoreboard #(
        .MaxOutstanding(MaxOutstanding)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set_i    (w_set),
        .set_rd_i (w_rd),
        .clr_i    (acc_rsp_valid_i),
        .clr_rd_i (acc_rsp_rd_i),
        .mask_o   (w_mask),
        .full_o   (w_sb_full),
        .busy_o   (w_sb_busy)
    );

    assign instr_ready_o          = r_instr_ready;
    assign prd_req_o.q_instr_data = (r_state == ST_PREDECODE) ? r_instr : '0;
    assign acc_req_valid_o        = r_acc_valid;
    assign acc_req_instr_o        = r_req.instr;
    assign acc_req_rs_o           = r_req.rs;
    assign acc_req_rd_o           = r_req.rd;
    assign acc_rsp_ready_o        = 1'b1;
    assign illegal_o              = r_illegal;
    assign wb_pending_o           = w_mask;
    assign busy_o                 = (r_state != ST_IDLE) || w_sb_busy;

endmodule

// File: tb/tb_acc_offload_requester.sv
// Randomized self-checking bench for acc_offload_requester (default build).
module tb_acc_offload_requester;
    import acc_pkg::*;

    localparam int MAXO = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [31:0]       instr_data_i;
    logic [2:0][31:0]  rs_i;
    logic [2:0]        rs_valid_i;
    acc_prd_req_t      prd_req_o;
    acc_prd_rsp_t      prd_rsp_i;
    logic              acc_req_valid_o;
    logic              acc_req_ready_i;
    logic [31:0]       acc_req_instr_o;
    logic [2:0][31:0]  acc_req_rs_o;
    logic [4:0]        acc_req_rd_o;
    logic              acc_rsp_valid_i;
    logic [4:0]        acc_rsp_rd_i;
    logic              acc_rsp_ready_o;
    logic              illegal_o;
    logic [31:0]       wb_pending_o;
    logic              busy_o;

    acc_offload_requester #(
        .NumRs(3), .DataWidth(32), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_data_i(instr_data_i), .rs_i(rs_i), .rs_valid_i(rs_valid_i),
        .prd_req_o(prd_req_o), .prd_rsp_i(prd_rsp_i),
        .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
        .acc_req_instr_o(acc_req_instr_o), .acc_req_rs_o(acc_req_rs_o),
        .acc_req_rd_o(acc_req_rd_o),
        .acc_rsp_valid_i(acc_rsp_valid_i), .acc_rsp_rd_i(acc_rsp_rd_i),
        .acc_rsp_ready_o(acc_rsp_ready_o),
        .illegal_o(illegal_o), .wb_pending_o(wb_pending_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_step: 0 = free for a new instruction, 1 = being predecoded,
    // 2 = waiting for operands/writeback slot, 3 = offered to the accelerator
    int               m_step;
    logic [31:0]      m_instr;
    acc_prd_rsp_t     m_rsp;
    logic [31:0]      m_mask;
    int               m_count;
    bit               m_ill;
    logic [2:0][31:0] m_rs;

    function automatic logic [4:0] src_reg(input logic [31:0] ins, input int k);
        if (k == 0) return ins[19:15];
        if (k == 1) return ins[24:20];
        return ins[31:27];
    endfunction

    function automatic bit operands_ok();
        for (int k = 0; k < 3; k++)
            if (m_rsp.p_use_rs[k] && !(rs_valid_i[k] && !m_mask[src_reg(m_instr, k)]))
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit wb_ok();
        logic [4:0] rd = m_instr[11:7];
        return !m_rsp.p_writeback || rd == 0 || (!m_mask[rd] && m_count < MAXO);
    endfunction

    bit          mv_dec, mv_set;
    logic [31:0] mv_mask;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_step = 0; m_instr = '0; m_rsp = '0; m_mask = '0;
            m_count = 0; m_ill = 1'b0; m_rs = '0;
        end else begin
            mv_dec  = acc_rsp_valid_i && m_count > 0;
            mv_set  = m_step == 3 && acc_req_ready_i && m_rsp.p_writeback && m_instr[11:7] != 0;
            mv_mask = m_mask;
            if (mv_dec) mv_mask[acc_rsp_rd_i] = 1'b0;
            if (mv_set) mv_mask[m_instr[11:7]] = 1'b1;
            m_ill = (m_step == 1) && !prd_rsp_i.p_accept;
            if (m_step == 0) begin
                if (instr_valid_i) begin m_instr = instr_data_i; m_step = 1; end
            end else if (m_step == 1) begin
                m_rsp  = prd_rsp_i;
                m_step = prd_rsp_i.p_accept ? 2 : 0;
            end else if (m_step == 2) begin
                if (operands_ok() && wb_ok()) begin
                    for (int k = 0; k < 3; k++) m_rs[k] = m_rsp.p_use_rs[k] ? rs_i[k] : 32'h0;
                    m_step = 3;
                end
            end else begin
                if (acc_req_ready_i) m_step = 0;
            end
            m_mask  = mv_mask;
            m_count = m_count + int'(mv_set) - int'(mv_dec);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_i && cmp_en) begin
            chk("instr_ready", instr_ready_o, m_step == 0);
            chk("acc_valid", acc_req_valid_o, m_step == 3);
            chk("illegal", illegal_o, m_ill);
            chk("prd_req", prd_req_o.q_instr_data, (m_step == 1) ? m_instr : 32'h0);
            chk("wb_pending", wb_pending_o, m_mask);
            chk("busy", busy_o, m_step != 0 || m_count != 0);
            chk("rsp_ready", acc_rsp_ready_o, 1'b1);
            if (m_step == 3) begin
                chk("req_instr", acc_req_instr_o, m_instr);
                chk("req_rs", acc_req_rs_o, m_rs);
                chk("req_rd", acc_req_rd_o, m_instr[11:7]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] mk(input logic [4:0] r3, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [4:0] rd);
        return {r3, 2'b00, r2, r1, 3'b000, rd, 7'h2b};
    endfunction

    function automatic acc_prd_rsp_t rsp(input bit acc, input bit wb, input logic [2:0] use_rs);
        acc_prd_rsp_t r;
        r.p_accept = acc; r.p_writeback = wb; r.p_use_rs = use_rs;
        return r;
    endfunction

    // Returns at posedge+2 with the DUT ready to handshake in the coming cycle
    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = instr_ready_o;
        end
        if (!seen) chk("idle_timeout", 1'b0, 1'b1);
        @(posedge clk); #2;
    endtask

    // Handshake in T0, predecode response during T1; returns at T2+2
    task automatic send(input logic [31:0] ins, input acc_prd_rsp_t r);
        instr_valid_i = 1'b1; instr_data_i = ins;
        @(posedge clk); #2;
        instr_valid_i = 1'b0; prd_rsp_i = r;
        @(posedge clk); #2;
        prd_rsp_i = 5'($urandom);
    endtask

    task automatic respond(input logic [4:0] rd);
        @(posedge clk); #2;
        acc_rsp_valid_i = 1'b1; acc_rsp_rd_i = rd;
        @(posedge clk); #2;
        acc_rsp_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        return mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endfunction

    task automatic rand_response();
        acc_rsp_valid_i = 1'b0;
        if (m_mask != 0 && $urandom_range(0, 3) == 0) begin
            for (int t = 0; t < 64 && !acc_rsp_valid_i; t++) begin
                acc_rsp_rd_i = 5'($urandom_range(1, 31));
                if (m_mask[acc_rsp_rd_i]) acc_rsp_valid_i = 1'b1;
            end
        end else if (m_count == 0 && $urandom_range(0, 19) == 0) begin
            acc_rsp_valid_i = 1'b1;
            acc_rsp_rd_i    = 5'($urandom);
        end
    endtask

    localparam logic [31:0] VA = 32'h1111_0001;
    localparam logic [31:0] VB = 32'h2222_0002;
    localparam logic [31:0] VC = 32'h3333_0003;

    bit seen_ready;
    bit drained;

    initial begin
        rst_i = 1'b1; instr_valid_i = 1'b0; instr_data_i = '0;
        rs_i = '0; rs_valid_i = '0; prd_rsp_i = '0;
        acc_req_ready_i = 1'b0; acc_rsp_valid_i = 1'b0; acc_rsp_rd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr_ready", instr_ready_o, 1'b1);
        chk("rst_acc_valid", acc_req_valid_o, 1'b0);
        chk("rst_wb_pending", wb_pending_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rsp_ready", acc_rsp_ready_o, 1'b1);
        @(posedge clk); #2;
        rst_i = 1'b0; cmp_en = 1'b1;

        // Accepted: rs1=1 rs2=2 rs3=3 rd=5, use_rs=011, writeback
        rs_valid_i = 3'b111; rs_i[0] = VA; rs_i[1] = VB; rs_i[2] = VC;
        wait_idle();
        send(mk(5'd3, 5'd2, 5'd1, 5'd5), rsp(1, 1, 3'b011));
        @(negedge clk);
        chk("acc_t2_low", acc_req_valid_o, 1'b0);
        @(negedge clk);
        chk("acc_t3_high", acc_req_valid_o, 1'b1);
        chk("acc_t3_rs", acc_req_rs_o, {32'h0, VB, VA});
        chk("acc_t3_rd", acc_req_rd_o, 5'd5);
        acc_req_ready_i = 1'b1;
        @(posedge clk); #2;
        acc_req_ready_i = 1'b0;
        @(negedge clk);
        chk("acc_t4_mask", wb_pending_o, 32'h20);
        chk("acc_t4_ready", instr_ready_o, 1'b1);

        // RAW hazard on rs1=5
        wait_idle();
        acc_req_ready_i = 1'b1;
        send(mk(5'd0, 5'd0, 5'd5, 5'd0), rsp(1, 0, 3'b001));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("raw_stall", acc_req_valid_o, 1'b0);
        end
        respond(5'd5);
        @(negedge clk);
        chk("raw_clear_cycle", acc_req_valid_o, 1'b0);
        @(negedge clk);
        chk("raw_issue", acc_req_valid_o, 1'b1);
        chk("raw_rs", acc_req_rs_o, {32'h0, 32'h0, VA});
        @(posedge clk); #2;
        acc_req_ready_i = 1'b0;

        // Rejected instruction
        wait_idle();
        send(mk(5'd1, 5'd1, 5'd1, 5'd9), rsp(0, 1, 3'b111));
        @(negedge clk);
        chk("rej_illegal_t2", illegal_o, 1'b1);
        chk("rej_ready_t2", instr_ready_o, 1'b1);
        @(negedge clk);
        chk("rej_illegal_t3", illegal_o, 1'b0);
        chk("rej_no_req", acc_req_valid_o, 1'b0);

        // Outstanding limit of two
        acc_req_ready_i = 1'b1;
        wait_idle(); send(mk(0, 0, 0, 5'd6), rsp(1, 1, 3'b000));
        wait_idle(); send(mk(0, 0, 0, 5'd7), rsp(1, 1, 3'b000));
        wait_idle(); send(mk(0, 0, 0, 5'd8), rsp(1, 1, 3'b000));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lim_stall", acc_req_valid_o, 1'b0);
        end
        chk("lim_mask_full", wb_pending_o, 32'h0000_00c0);
        respond(5'd6);
        @(negedge clk);
        chk("lim_release_wait", acc_req_valid_o, 1'b0);
        @(negedge clk);
        chk("lim_release", acc_req_valid_o, 1'b1);
        @(posedge clk); #2;
        @(negedge clk);
        chk("lim_mask", wb_pending_o, 32'h0000_0180);
        respond(5'd7);
        acc_req_ready_i = 1'b0;
        wait_idle(); send(mk(0, 0, 0, 5'd9), rsp(1, 1, 3'b000));
        @(posedge clk); #2;
        acc_req_ready_i = 1'b1; acc_rsp_valid_i = 1'b1; acc_rsp_rd_i = 5'd8;
        @(posedge clk); #2;
        acc_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("coincide_mask", wb_pending_o, 32'h0000_0200);
        chk("coincide_busy", busy_o, 1'b1);
        wait_idle(); send(mk(0, 0, 0, 5'd10), rsp(1, 1, 3'b000));
        wait_idle();
        chk("two_out_mask", wb_pending_o, 32'h0000_0600);
        respond(5'd9);
        respond(5'd10);

        // rd=0 with writeback, then a stray response
        wait_idle(); send(mk(0, 0, 0, 5'd0), rsp(1, 1, 3'b000));
        wait_idle();
        @(negedge clk);
        chk("rd0_mask", wb_pending_o, 32'h0);
        chk("rd0_busy", busy_o, 1'b0);
        respond(5'd3);
        @(negedge clk);
        chk("stray_busy", busy_o, 1'b0);
        wait_idle(); send(mk(0, 0, 0, 5'd4), rsp(1, 1, 3'b000));
        wait_idle();
        @(negedge clk);
        chk("after_stray_mask", wb_pending_o, 32'h10);

        // Reset while offering a request
        acc_req_ready_i = 1'b0;
        wait_idle(); send(mk(0, 0, 0, 5'd12), rsp(1, 1, 3'b000));
        @(posedge clk); #2;
        @(negedge clk);
        chk("pre_reset_issue", acc_req_valid_o, 1'b1);
        #1 rst_i = 1'b1;
        #1;
        chk("async_rst_ready", instr_ready_o, 1'b1);
        chk("async_rst_valid", acc_req_valid_o, 1'b0);
        chk("async_rst_mask", wb_pending_o, 32'h0);
        chk("async_rst_busy", busy_o, 1'b0);
        chk("async_rst_illegal", illegal_o, 1'b0);
        @(posedge clk); #2;
        rst_i = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            seen_ready = instr_ready_o;
            @(posedge clk); #2;
            if (instr_valid_i && seen_ready) begin
                instr_valid_i = 1'b0;
                prd_rsp_i = rsp($urandom_range(0, 99) < 85, $urandom_range(0, 9) < 6,
                                3'($urandom));
            end else begin
                prd_rsp_i = 5'($urandom);
                if (!instr_valid_i && $urandom_range(0, 1) == 1) begin
                    instr_valid_i = 1'b1;
                    instr_data_i  = rand_instr();
                end
            end
            for (int k = 0; k < 3; k++) begin
                rs_valid_i[k] = $urandom_range(0, 4) != 0;
                rs_i[k]       = $urandom;
            end
            acc_req_ready_i = $urandom_range(0, 9) < 6;
            rand_response();
        end

        // Drain everything outstanding
        instr_valid_i = 1'b0; acc_req_ready_i = 1'b1; rs_valid_i = 3'b111;
        drained = 1'b0;
        for (int c = 0; c < 300 && !drained; c++) begin
            @(posedge clk); #2;
            acc_rsp_valid_i = 1'b0;
            for (int r = 1; r < 32 && !acc_rsp_valid_i; r++)
                if (m_mask[r]) begin acc_rsp_valid_i = 1'b1; acc_rsp_rd_i = 5'(r); end
            @(negedge clk);
            drained = (m_step == 0) && (m_mask == 0) && (m_count == 0);
        end
        acc_rsp_valid_i = 1'b0;
        chk("drain_done", drained, 1'b1);
        @(negedge clk);
        chk("final_busy", busy_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
